// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one 32-bit CGRA ALU among NREQ requesters.
// Define ALU_ARB_PERF_EN to add the perf_ops response-handshake counter.
module alu_arbiter #(
    parameter int NREQ    = 4,
    parameter int W       = 32,
    parameter int MUL_LAT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [4*NREQ-1:0] req_op,
    input  logic [W*NREQ-1:0] req_a,
    input  logic [W*NREQ-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [W-1:0]      rsp_data,
    output logic [2:0]        rsp_id,
    output logic              rsp_err
`ifdef ALU_ARB_PERF_EN
    ,
    output logic [31:0]       perf_ops
`endif
);

    localparam logic [3:0] OP_MUL = 4'd2;
    localparam int SW = $clog2(W);

    typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_e;

    state_e         state_q;
    logic [2:0]     last_q;
    logic [3:0]     cnt_q;
    logic [3:0]     op_q;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic           rsp_valid_q;
    logic [W-1:0]   rsp_data_q;
    logic [2:0]     rsp_id_q;
    logic           rsp_err_q;

    logic           found;
    logic [2:0]     gidx;
    logic [NREQ-1:0] grant_oh;
    logic [3:0]     g_op;
    logic [W-1:0]   g_a;
    logic [W-1:0]   g_b;
    logic           win;
    logic           accept;
    logic           g_long;

    logic [3:0]     alu_op;
    logic [W-1:0]   alu_a;
    logic [W-1:0]   alu_b;
    logic [W-1:0]   alu_res;
    logic           alu_err;

    function automatic logic [W-1:0] alu_f(
        input logic [3:0]   op,
        input logic [W-1:0] a,
        input logic [W-1:0] b
    );
        logic [W-1:0] r;
        r = '0;
        unique case (op)
            4'd0: r = a + b;
            4'd1: r = a - b;
            4'd2: r = W'(a[15:0]) * W'(b[15:0]);
            4'd3: r = (b >= W) ? '0 : a << b[SW-1:0];
            4'd4: r = (b >= W) ? '0 : a >> b[SW-1:0];
            4'd5: r = W'(a < b);
            4'd6: r = W'(a > b);
            4'd7: r = W'(a == b);
            default: r = '0;
        endcase
        return r;
    endfunction

    // Two downward passes: the second overrides with the nearest valid index above last_q.
    always_comb begin
        found = 1'b0;
        gidx  = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                gidx  = 3'(i);
                found = 1'b1;
            end
        end
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i] && (3'(i) > last_q)) begin
                gidx = 3'(i);
            end
        end
    end

    always_comb begin
        g_op     = '0;
        g_a      = '0;
        g_b      = '0;
        grant_oh = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (3'(i) == gidx) begin
                g_op        = req_op[4*i +: 4];
                g_a         = req_a[W*i +: W];
                g_b         = req_b[W*i +: W];
                grant_oh[i] = found;
            end
        end
    end

    assign win       = (state_q == IDLE) || ((state_q == HOLD) && rsp_ready);
    assign accept    = win && found && !rst;
    assign req_ready = accept ? grant_oh : '0;
    assign g_long    = (g_op == OP_MUL) && (MUL_LAT > 1);

    assign alu_op  = (state_q == EXEC) ? op_q : g_op;
    assign alu_a   = (state_q == EXEC) ? a_q : g_a;
    assign alu_b   = (state_q == EXEC) ? b_q : g_b;
    assign alu_res = alu_f(alu_op, alu_a, alu_b);
    assign alu_err = alu_op[3];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            last_q      <= 3'(NREQ - 1);
            cnt_q       <= '0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE, HOLD: begin
                    if (accept) begin
                        last_q   <= gidx;
                        rsp_id_q <= gidx;
                        op_q     <= g_op;
                        a_q      <= g_a;
                        b_q      <= g_b;
                        if (g_long) begin
                            state_q     <= EXEC;
                            cnt_q       <= 4'(MUL_LAT - 1);
                            rsp_valid_q <= 1'b0;
                        end else begin
                            state_q     <= HOLD;
                            rsp_valid_q <= 1'b1;
                            rsp_data_q  <= alu_res;
                            rsp_err_q   <= alu_err;
                        end
                    end else if ((state_q == HOLD) && rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
                EXEC: begin
                    if (cnt_q == 4'd1) begin
                        state_q     <= HOLD;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= alu_res;
                        rsp_err_q   <= alu_err;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_err   = rsp_err_q;

`ifdef ALU_ARB_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_q <= '0;
        end else if (rsp_valid_q && rsp_ready && (perf_q != '1)) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_ops = perf_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: vector table, scoreboard, corner sequences.
module tb_alu_arbiter;

    localparam int NREQ    = 4;
    localparam int W       = 32;
    localparam int MUL_LAT = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [4*NREQ-1:0] req_op;
    logic [W*NREQ-1:0] req_a;
    logic [W*NREQ-1:0] req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [W-1:0]      rsp_data;
    logic [2:0]        rsp_id;
    logic              rsp_err;
`ifdef ALU_ARB_PERF_EN
    logic [31:0]       perf_ops;
`endif

    alu_arbiter #(.NREQ(NREQ), .W(W), .MUL_LAT(MUL_LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_err   (rsp_err)
`ifdef ALU_ARB_PERF_EN
        ,
        .perf_ops  (perf_ops)
`endif
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    typedef struct {
        logic [2:0]  id;
        logic [31:0] data;
        logic        err;
    } rsp_t;

    rsp_t sb[$];
    rsp_t e;

    function automatic rsp_t model(input int id, input logic [3:0] op,
                                   input logic [31:0] a, input logic [31:0] b);
        rsp_t r;
        r.id   = 3'(id);
        r.err  = 1'b0;
        r.data = 32'h0;
        case (op)
            4'd0: r.data = a + b;
            4'd1: r.data = a - b;
            4'd2: r.data = {16'h0, a[15:0]} * {16'h0, b[15:0]};
            4'd3: r.data = (b > 32'd31) ? 32'h0 : (a << b);
            4'd4: r.data = (b > 32'd31) ? 32'h0 : (a >> b);
            4'd5: r.data = (a < b) ? 32'd1 : 32'd0;
            4'd6: r.data = (a > b) ? 32'd1 : 32'd0;
            4'd7: r.data = (a == b) ? 32'd1 : 32'd0;
            default: r.err = 1'b1;
        endcase
        return r;
    endfunction

    // Scoreboard: pop on response handshake before pushing a same-cycle grant.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    n_tot++;
                    $display("FAIL sb_unexpected: got id %0d data %0h want none", rsp_id, rsp_data);
                end else begin
                    e = sb.pop_front();
                    chk("sb_data", rsp_data, e.data);
                    chk("sb_id", rsp_id, e.id);
                    chk("sb_err", rsp_err, e.err);
                end
            end
            if (req_ready != '0) begin
                chk("grant_onehot", $countones(req_ready), 1);
                for (int i = 0; i < NREQ; i++) begin
                    if (req_ready[i]) begin
                        sb.push_back(model(i, req_op[4*i +: 4], req_a[32*i +: 32], req_b[32*i +: 32]));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic [3:0] op,
                           input logic [31:0] a, input logic [31:0] b);
        req_op[4*i +: 4] = op;
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        tick();
        samp();
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] data;
        logic        err;
    } vec_t;

    vec_t vt[13];
    logic got;

    initial begin
        vt[0]  = '{4'd0, 32'hFFFF_FFFF, 32'd2, 32'd1, 1'b0};
        vt[1]  = '{4'd1, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0};
        vt[2]  = '{4'd2, 32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFE_0001, 1'b0};
        vt[3]  = '{4'd3, 32'd1, 32'd31, 32'h8000_0000, 1'b0};
        vt[4]  = '{4'd3, 32'd1, 32'd32, 32'd0, 1'b0};
        vt[5]  = '{4'd4, 32'h8000_0000, 32'd40, 32'd0, 1'b0};
        vt[6]  = '{4'd4, 32'h8000_0000, 32'd31, 32'd1, 1'b0};
        vt[7]  = '{4'd5, 32'd1, 32'hFFFF_FFFF, 32'd1, 1'b0};
        vt[8]  = '{4'd5, 32'd5, 32'd5, 32'd0, 1'b0};
        vt[9]  = '{4'd6, 32'hFFFF_FFFF, 32'd0, 32'd1, 1'b0};
        vt[10] = '{4'd7, 32'h1234, 32'h1234, 32'd1, 1'b0};
        vt[11] = '{4'd9, 32'd5, 32'd6, 32'd0, 1'b1};
        vt[12] = '{4'd15, 32'd1, 32'd1, 32'd0, 1'b1};

        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        tick();
        samp();
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_req_ready", req_ready, 0);
`ifdef ALU_ARB_PERF_EN
        chk("rst_perf", perf_ops, 0);
`endif
        tick();
        rst = 1'b0;

        // Basic ADD from requester 0
        set_req(0, 4'd0, 32'd5, 32'd7);
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        samp();
        chk("add_ready", req_ready, 4'b0001);
        chk("add_noval", rsp_valid, 0);
        tick();
        req_valid = '0;
        samp();
        chk("add_valid", rsp_valid, 1);
        chk("add_data", rsp_data, 12);
        chk("add_id", rsp_id, 0);
        chk("add_err", rsp_err, 0);
        tick();
`ifdef ALU_ARB_PERF_EN
        samp();
        chk("perf_one", perf_ops, 1);
        tick();
`endif

        // All valid: rotation from a fresh reset
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 4'd1, 32'(100 + 16 * i), 32'(i));
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            samp();
            chk("rr_grant", req_ready, 64'(1 << (k % 4)));
            tick();
        end
        req_valid = '0;
        samp();
        chk("rr_last_valid", rsp_valid, 1);
        chk("rr_last_id", rsp_id, 3);
        chk("rr_last_data", rsp_data, 145);
        tick();

        // MUL latency, no grant during EXEC, back-to-back grant on handshake
        set_req(2, 4'd2, 32'hFFFF_0003, 32'h0001_0004);
        req_valid = 4'b0100;
        samp();
        chk("mul_ready", req_ready, 4'b0100);
        tick();
        set_req(1, 4'd0, 32'd10, 32'd20);
        req_valid = 4'b0010;
        for (int c = 1; c <= MUL_LAT; c++) begin
            samp();
            if (c < MUL_LAT) begin
                chk("mul_exec_valid", rsp_valid, 0);
                chk("mul_exec_ready", req_ready, 0);
            end else begin
                chk("mul_valid", rsp_valid, 1);
                chk("mul_data", rsp_data, 12);
                chk("mul_id", rsp_id, 2);
                chk("mul_next_grant", req_ready, 4'b0010);
            end
            tick();
        end
        req_valid = '0;
        samp();
        chk("after_mul_data", rsp_data, 30);
        chk("after_mul_id", rsp_id, 1);
        tick();

        // Backpressure in HOLD
        rsp_ready = 1'b0;
        set_req(3, 4'd0, 32'd1, 32'd2);
        req_valid = 4'b1000;
        samp();
        chk("hold_grant", req_ready, 4'b1000);
        tick();
        set_req(0, 4'd7, 32'd3, 32'd3);
        req_valid = 4'b0001;
        for (int c = 0; c < 5; c++) begin
            samp();
            chk("hold_valid", rsp_valid, 1);
            chk("hold_data", rsp_data, 3);
            chk("hold_id", rsp_id, 3);
            chk("hold_noready", req_ready, 0);
            tick();
        end
        rsp_ready = 1'b1;
        samp();
        chk("hold_release_grant", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        samp();
        chk("hold_next_data", rsp_data, 1);
        chk("hold_next_id", rsp_id, 0);
        tick();

        // Vector table through requester 0
        for (int v = 0; v < 13; v++) begin
            set_req(0, vt[v].op, vt[v].a, vt[v].b);
            req_valid = 4'b0001;
            samp();
            chk("tbl_ready", req_ready, 4'b0001);
            tick();
            req_valid = '0;
            got = 1'b0;
            for (int c = 0; c < 10 && !got; c++) begin
                samp();
                if (rsp_valid) got = 1'b1;
                else tick();
            end
            chk("tbl_rsp_seen", got, 1);
            chk("tbl_data", rsp_data, vt[v].data);
            chk("tbl_err", rsp_err, vt[v].err);
            tick();
        end

        // Reset during EXEC
        set_req(1, 4'd2, 32'd7, 32'd6);
        req_valid = 4'b0010;
        samp();
        chk("rx_grant", req_ready, 4'b0010);
        tick();
        for (int i = 0; i < NREQ; i++) set_req(i, 4'd0, 32'(i), 32'd1);
        req_valid = 4'b1111;
        samp();
        chk("rx_exec_ready", req_ready, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("rx_rsp_valid", rsp_valid, 0);
        chk("rx_req_ready", req_ready, 0);
        chk("rx_rsp_data", rsp_data, 0);
`ifdef ALU_ARB_PERF_EN
        chk("rx_perf", perf_ops, 0);
`endif
        tick();
        samp();
        tick();
        rst = 1'b0;
        samp();
        chk("rx_first_grant", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        samp();
        chk("rx_rsp_id", rsp_id, 0);
        chk("rx_rsp_data2", rsp_data, 1);
        tick();
        samp();
        chk("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
